ysyx_23060187_ifu: RTL and testbench

YSYX_23060187_IFU -- requirements
Module: ysyx_23060187_ifu

---
 rtl/ysyx_23060187_pkg.sv | 21 ++
 rtl/ysyx_23060187_ifu.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_23060187_ifu.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060187_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, fault codes
// and the bus response code that means success.
package ysyx_23060187_pkg;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_RESP    = 2'd1,
        ST_DELIVER = 2'd2,
        ST_WAIT_PC = 2'd3
    } ifu_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'd0,
        FAULT_MISALIGN  = 2'd1,
        FAULT_BUS       = 2'd2,
        FAULT_TIMEOUT   = 2'd3
    } ifu_fault_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit: one outstanding read, response timeout with stale
// beat draining, and a registered instruction slot towards decode.
module ysyx_23060187_ifu
    import ysyx_23060187_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic [1:0]  dbg_state
);

    // Valid/ready: a transfer happens on a rising edge where both are high;
    // the source keeps valid and payload stable until that edge.

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [1:0]  fault_q, fault_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        stale_q, stale_d;

    logic misaligned;
    logic ar_fire;
    logic timeout;
    logic deliver_fire;

    assign misaligned   = (state_q == ST_REQ) && (pc_q[1:0] != 2'b00);
    assign ar_fire      = arvalid && arready;
    assign timeout      = (state_q == ST_RESP) && !rvalid && (cnt_q == TIMEOUT_LAST);
    assign deliver_fire = (state_q == ST_DELIVER) && inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (misaligned) begin
                    state_d = ST_DELIVER;
                end else if (ar_fire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rvalid || timeout) begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (inst_ready) begin
                    state_d = (pend_valid_q || npc_valid) ? ST_REQ : ST_WAIT_PC;
                end
            end
            ST_WAIT_PC: begin
                if (npc_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // No new request while a timed-out beat may still arrive, so at most one
    // read is ever in flight on the bus.
    always_comb begin
        arvalid    = 1'b0;
        rready     = 1'b0;
        inst_valid = 1'b0;
        if (!rst) begin
            arvalid    = (state_q == ST_REQ) && (pc_q[1:0] == 2'b00) && !stale_q;
            rready     = (state_q == ST_RESP) || stale_q;
            inst_valid = (state_q == ST_DELIVER);
        end
    end

    always_comb begin
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        stale_d      = stale_q;

        if (misaligned) begin
            inst_d    = 32'h0;
            inst_pc_d = pc_q;
            fault_d   = FAULT_MISALIGN;
        end

        if (ar_fire) begin
            inst_pc_d = pc_q;
            cnt_d     = 8'd0;
        end else if (state_q == ST_RESP) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (state_q == ST_RESP) begin
            if (rvalid) begin
                if (rresp == RESP_OKAY) begin
                    inst_d  = rdata;
                    fault_d = FAULT_NONE;
                end else begin
                    inst_d  = 32'h0;
                    fault_d = FAULT_BUS;
                end
            end else if (timeout) begin
                inst_d  = 32'h0;
                fault_d = FAULT_TIMEOUT;
                stale_d = 1'b1;
            end
        end else if (stale_q && rvalid) begin
            stale_d = 1'b0;
        end

        // A pulse arriving together with the handshake is newer than any pending one.
        if (deliver_fire) begin
            pend_valid_d = 1'b0;
            if (npc_valid) begin
                pc_d = npc;
            end else if (pend_valid_q) begin
                pc_d = pend_pc_q;
            end
        end else if (state_q == ST_WAIT_PC) begin
            if (npc_valid) begin
                pc_d = npc;
            end
        end else if (npc_valid) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = npc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            cnt_q        <= 8'd0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            fault_q      <= FAULT_NONE;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            stale_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            stale_q      <= stale_d;
        end
    end

    assign araddr     = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = fault_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Directed bench for the fetch unit: a default-parameter instance for the
// main scenarios and a TIMEOUT_CYCLES=4 instance for the timeout path.
module tb_ysyx_23060187_ifu;
    import ysyx_23060187_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] npc = 32'h0;
    logic        npc_valid = 1'b0;
    logic [1:0]  dbg_state;

    logic [31:0] t_araddr;
    logic        t_arvalid;
    logic        t_arready = 1'b0;
    logic [31:0] t_rdata = 32'h0;
    logic [1:0]  t_rresp = 2'b00;
    logic        t_rvalid = 1'b0;
    logic        t_rready;
    logic [31:0] t_inst;
    logic [31:0] t_inst_pc;
    logic [1:0]  t_inst_fault;
    logic        t_inst_valid;
    logic        t_inst_ready = 1'b0;
    logic [31:0] t_npc = 32'h0;
    logic        t_npc_valid = 1'b0;
    logic [1:0]  t_dbg_state;

    int checks = 0;
    int errors = 0;

    ysyx_23060187_ifu dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .npc(npc), .npc_valid(npc_valid), .dbg_state(dbg_state)
    );

    ysyx_23060187_ifu #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst(rst),
        .araddr(t_araddr), .arvalid(t_arvalid), .arready(t_arready),
        .rdata(t_rdata), .rresp(t_rresp), .rvalid(t_rvalid), .rready(t_rready),
        .inst(t_inst), .inst_pc(t_inst_pc), .inst_fault(t_inst_fault),
        .inst_valid(t_inst_valid), .inst_ready(t_inst_ready),
        .npc(t_npc), .npc_valid(t_npc_valid), .dbg_state(t_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Entered with the DUT in REQ; leaves it in DELIVER.
    task automatic do_fetch(input logic [31:0] exp_addr, input int ar_wait, input int r_wait,
                            input logic [31:0] data, input logic [1:0] resp);
        checks++;
        if (arvalid !== 1'b1 || araddr !== exp_addr) begin
            errors++;
            $display("FAIL ar_start: arvalid=%b araddr=%h, want 1 %h", arvalid, araddr, exp_addr);
        end
        for (int i = 0; i < ar_wait; i++) begin
            arready = 1'b0;
            tick();
            checks++;
            if (arvalid !== 1'b1 || araddr !== exp_addr) begin
                errors++;
                $display("FAIL ar_hold: arvalid=%b araddr=%h, want 1 %h", arvalid, araddr, exp_addr);
            end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < r_wait; i++) begin
            checks++;
            if (rready !== 1'b1 || arvalid !== 1'b0 || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL resp_wait: rready=%b arvalid=%b inst_valid=%b, want 1 0 0",
                         rready, arvalid, inst_valid);
            end
            tick();
        end
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        rresp  = 2'b00;
    endtask

    // Entered in DELIVER; checks the slot, stalls, then handshakes.
    task automatic deliver_check(input logic [31:0] e_inst, input logic [31:0] e_pc,
                                 input logic [1:0] e_fault, input int hold,
                                 input bit use_npc, input logic [31:0] next_pc);
        checks++;
        if (inst_valid !== 1'b1 || inst !== e_inst || inst_pc !== e_pc || inst_fault !== e_fault) begin
            errors++;
            $display("FAIL deliver: valid=%b inst=%h pc=%h fault=%0d, want 1 %h %h %0d",
                     inst_valid, inst, inst_pc, inst_fault, e_inst, e_pc, e_fault);
        end
        for (int i = 0; i < hold; i++) begin
            inst_ready = 1'b0;
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== e_inst || inst_pc !== e_pc || inst_fault !== e_fault) begin
                errors++;
                $display("FAIL deliver_hold: valid=%b inst=%h pc=%h fault=%0d, want 1 %h %h %0d",
                         inst_valid, inst, inst_pc, inst_fault, e_inst, e_pc, e_fault);
            end
        end
        inst_ready = 1'b1;
        if (use_npc) begin
            npc       = next_pc;
            npc_valid = 1'b1;
        end
        tick();
        inst_ready = 1'b0;
        npc_valid  = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake_once: inst_valid=%b, want 0", inst_valid);
        end
        if (use_npc) begin
            checks++;
            if (arvalid !== (next_pc[1:0] == 2'b00) || araddr !== next_pc) begin
                errors++;
                $display("FAIL npc_fetch: arvalid=%b araddr=%h, want %b %h",
                         arvalid, araddr, (next_pc[1:0] == 2'b00), next_pc);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: arvalid=%b rready=%b inst_valid=%b, want 0 0 0",
                     arvalid, rready, inst_valid);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 2'd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: inst=%h pc=%h fault=%0d state=%0d, want 0 0 0 0",
                     inst, inst_pc, inst_fault, dbg_state);
        end
        checks++;
        if (t_arvalid !== 1'b0 || t_rready !== 1'b0 || t_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_t: arvalid=%b rready=%b inst_valid=%b, want 0 0 0",
                     t_arvalid, t_rready, t_inst_valid);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic;
        do_fetch(32'h8000_0000, 0, 0, 32'h0010_0093, RESP_OKAY);
        deliver_check(32'h0010_0093, 32'h8000_0000, 2'd0, 0, 1'b1, 32'h8000_0004);
    endtask

    task automatic test_wait_states;
        do_fetch(32'h8000_0004, 3, 5, 32'h0000_0513, RESP_OKAY);
        deliver_check(32'h0000_0513, 32'h8000_0004, 2'd0, 4, 1'b1, 32'h8000_0002);
    endtask

    task automatic test_misaligned;
        checks++;
        if (arvalid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_no_ar: arvalid=%b, want 0", arvalid);
        end
        tick();
        deliver_check(32'h0, 32'h8000_0002, 2'd1, 0, 1'b1, 32'h8000_000C);
    endtask

    task automatic test_bus_error;
        do_fetch(32'h8000_000C, 0, 1, 32'hABCD_1234, 2'b10);
        deliver_check(32'h0, 32'h8000_000C, 2'd2, 0, 1'b1, 32'h8000_0010);
        do_fetch(32'h8000_0010, 1, 0, 32'h0041_0113, RESP_OKAY);
        deliver_check(32'h0041_0113, 32'h8000_0010, 2'd0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_wait_pc;
        tick();
        tick();
        checks++;
        if (arvalid !== 1'b0 || dbg_state !== 2'd3) begin
            errors++;
            $display("FAIL wait_pc_idle: arvalid=%b state=%0d, want 0 3", arvalid, dbg_state);
        end
        npc       = 32'h8000_0030;
        npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0030) begin
            errors++;
            $display("FAIL wait_pc_latency: arvalid=%b araddr=%h, want 1 80000030", arvalid, araddr);
        end
    endtask

    task automatic test_pending_npc;
        do_fetch(32'h8000_0030, 0, 0, 32'h0000_0073, RESP_OKAY);
        npc       = 32'h8000_0020;
        npc_valid = 1'b1;
        tick();
        npc       = 32'h8000_0040;
        tick();
        npc_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL pending_hold: inst_valid=%b arvalid=%b, want 1 0", inst_valid, arvalid);
        end
        deliver_check(32'h0000_0073, 32'h8000_0030, 2'd0, 0, 1'b0, 32'h0);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0040) begin
            errors++;
            $display("FAIL pending_fetch: arvalid=%b araddr=%h, want 1 80000040", arvalid, araddr);
        end
    endtask

    task automatic test_same_cycle_resp;
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h1111_1111;
        tick();
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || rready !== 1'b1) begin
            errors++;
            $display("FAIL early_resp_ignored: inst_valid=%b rready=%b, want 0 1", inst_valid, rready);
        end
        rvalid = 1'b1;
        rdata  = 32'h2222_2222;
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        deliver_check(32'h2222_2222, 32'h8000_0040, 2'd0, 0, 1'b1, 32'h8000_0050);
    endtask

    task automatic test_reset_mid;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL mid_resp: rready=%b, want 1", rready);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || inst !== 32'h0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: arvalid=%b rready=%b inst=%h valid=%b, want 0 0 0 0",
                     arvalid, rready, inst, inst_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0000 || rready !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: arvalid=%b araddr=%h rready=%b, want 1 80000000 0",
                     arvalid, araddr, rready);
        end
        do_fetch(32'h8000_0000, 0, 0, 32'h0000_0001, RESP_OKAY);
        deliver_check(32'h0000_0001, 32'h8000_0000, 2'd0, 0, 1'b1, 32'hFFFF_FFFC);
    endtask

    task automatic test_wrap;
        do_fetch(32'hFFFF_FFFC, 0, 0, 32'h0000_006F, RESP_OKAY);
        deliver_check(32'h0000_006F, 32'hFFFF_FFFC, 2'd0, 0, 1'b1, 32'h0000_0000);
    endtask

    task automatic test_timeout;
        checks++;
        if (t_arvalid !== 1'b1 || t_araddr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL to_start: arvalid=%b araddr=%h, want 1 80000000", t_arvalid, t_araddr);
        end
        t_arready = 1'b1;
        tick();
        t_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (t_inst_valid !== 1'b0 || t_rready !== 1'b1 || t_dbg_state !== 2'd1) begin
                errors++;
                $display("FAIL to_wait: valid=%b rready=%b state=%0d, want 0 1 1",
                         t_inst_valid, t_rready, t_dbg_state);
            end
            tick();
        end
        checks++;
        if (t_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_4th_cycle: valid=%b, want 0", t_inst_valid);
        end
        tick();
        checks++;
        if (t_inst_valid !== 1'b1 || t_inst_fault !== 2'd3 || t_inst !== 32'h0 || t_inst_pc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL to_deliver: valid=%b fault=%0d inst=%h pc=%h, want 1 3 0 80000000",
                     t_inst_valid, t_inst_fault, t_inst, t_inst_pc);
        end
        t_inst_ready = 1'b1;
        t_npc        = 32'h8000_0020;
        t_npc_valid  = 1'b1;
        tick();
        t_inst_ready = 1'b0;
        t_npc_valid  = 1'b0;
        checks++;
        if (t_rready !== 1'b1 || t_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL to_drain_wait: rready=%b arvalid=%b, want 1 0", t_rready, t_arvalid);
        end
        t_rvalid = 1'b1;
        t_rdata  = 32'hDEAD_BEEF;
        tick();
        t_rvalid = 1'b0;
        t_rdata  = 32'h0;
        checks++;
        if (t_rready !== 1'b0 || t_arvalid !== 1'b1 || t_araddr !== 32'h8000_0020 || t_inst !== 32'h0) begin
            errors++;
            $display("FAIL to_drained: rready=%b arvalid=%b araddr=%h inst=%h, want 0 1 80000020 0",
                     t_rready, t_arvalid, t_araddr, t_inst);
        end
        t_arready = 1'b1;
        tick();
        t_arready = 1'b0;
        t_rvalid  = 1'b1;
        t_rdata   = 32'h0000_0013;
        tick();
        t_rvalid  = 1'b0;
        t_rdata   = 32'h0;
        checks++;
        if (t_inst_valid !== 1'b1 || t_inst !== 32'h0000_0013 || t_inst_fault !== 2'd0 || t_inst_pc !== 32'h8000_0020) begin
            errors++;
            $display("FAIL to_next_fetch: valid=%b inst=%h fault=%0d pc=%h, want 1 00000013 0 80000020",
                     t_inst_valid, t_inst, t_inst_fault, t_inst_pc);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_misaligned();
        test_bus_error();
        test_wait_pc();
        test_pending_npc();
        test_same_cycle_resp();
        test_reset_mid();
        test_wrap();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
